// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one uart_tx transmitter among NUM_REQ byte-stream requesters.
// Arbitration is round-robin at packet granularity. A granted requester keeps
// the transmitter until it hands over a byte flagged last, or until it leaves
// req_valid low in LOAD for HOLD_TIMEOUT cycles (0 disables that revocation).
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     per-requester byte available
//   req_data      per-requester byte, requester i on [8i+7:8i]
//   req_last      byte closes the requester's packet
//   req_ready     byte accepted this cycle (only the lock holder, only in LOAD)
//   tx_go         one-cycle start pulse to uart_tx
//   tx_byte       byte to uart_tx, held from tx_go until the next load
//   tx_busy       uart_tx busy, rises the cycle after tx_go
//   grant_valid   a requester holds the lock
//   grant_id      lock holder index
//   timeout_err   one-cycle pulse when a lock is revoked by the hold timeout

// Per-requester slice: ready qualification and the AND-OR data/last select.
module uart_tx_arbiter_lane (
  input  logic       load_en,
  input  logic       sel,
  input  logic       valid,
  input  logic [7:0] data,
  input  logic       last,
  output logic       ready,
  output logic [7:0] data_sel,
  output logic       last_sel
);
  assign ready    = load_en & sel & valid;
  assign data_sel = sel ? data : 8'h00;
  assign last_sel = sel & last;
endmodule

module uart_tx_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int HOLD_TIMEOUT = 4096,
  localparam int GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_go,
  output logic [7:0]           tx_byte,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [GW-1:0]        grant_id,
  output logic                 timeout_err
);

  localparam int CW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] HOLD_LAST = (HOLD_TIMEOUT > 0) ? CW'(HOLD_TIMEOUT - 1) : '0;
  localparam logic [GW-1:0] RR_INIT   = GW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_GO    = 3'd2,
    S_GUARD = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [GW-1:0] rr;
  logic [CW-1:0] hold_cnt;
  logic          last_q;

  logic                      load_en;
  logic [NUM_REQ-1:0]        sel_vec;
  logic [NUM_REQ-1:0][7:0]   lane_data;
  logic [NUM_REQ-1:0]        lane_last;
  logic [7:0]                sel_data;
  logic                      sel_last;
  logic                      sel_valid;
  logic                      xfer;
  logic                      tmo_hit;
  logic                      arb_go;
  logic                      win_found;
  logic [GW-1:0]             win_id;

  // Lanes
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign sel_vec[i] = (grant_id == GW'(i));
    uart_tx_arbiter_lane u_lane (
      .load_en  (load_en),
      .sel      (sel_vec[i]),
      .valid    (req_valid[i]),
      .data     (req_data[8*i +: 8]),
      .last     (req_last[i]),
      .ready    (req_ready[i]),
      .data_sel (lane_data[i]),
      .last_sel (lane_last[i])
    );
  end

  always_comb begin
    sel_data = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) sel_data = sel_data | lane_data[k];
  end

  assign sel_last  = |lane_last;
  assign sel_valid = |(req_valid & sel_vec);
  assign xfer      = load_en & sel_valid;

  // A stall only counts against the holder while it has nothing to offer;
  // a transfer in the same cycle always takes precedence.
  assign tmo_hit = (HOLD_TIMEOUT != 0) && (state == S_LOAD) && !sel_valid &&
                   (hold_cnt == HOLD_LAST);

  // Round-robin search starting one past the last releaser, wrapping mod NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int unsigned cand;
      cand = (int'(rr) + k) % NUM_REQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = GW'(cand);
      end
    end
  end

  // Waiting on tx_busy here keeps a frame still in flight across a reset intact.
  assign arb_go = (state == S_IDLE) && !tx_busy && win_found;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (arb_go) state_nxt = S_LOAD;
      S_LOAD: begin
        if (xfer)         state_nxt = S_GO;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_GO:    state_nxt = S_GUARD;
      // uart_tx only raises busy the cycle after go, so busy is not looked at here.
      S_GUARD: state_nxt = S_DRAIN;
      S_DRAIN: if (!tx_busy) state_nxt = last_q ? S_IDLE : S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    load_en = (state == S_LOAD);
    tx_go   = (state == S_GO);
  end

  // Grant, pointer, byte and hold-counter datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_valid <= 1'b0;
      grant_id    <= '0;
      rr          <= RR_INIT;
      tx_byte     <= 8'h00;
      last_q      <= 1'b0;
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (arb_go) begin
            grant_id    <= win_id;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            tx_byte  <= sel_data;
            last_q   <= sel_last;
            hold_cnt <= '0;
          end else if (tmo_hit) begin
            grant_valid <= 1'b0;
            rr          <= grant_id;
            timeout_err <= 1'b1;
            hold_cnt    <= '0;
          end else if ((HOLD_TIMEOUT != 0) && !(&hold_cnt)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (!tx_busy && last_q) begin
            grant_valid <= 1'b0;
            rr          <= grant_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
